// File: rtl/pov_column_scanner_if.sv
// Read port of the POV column RAM, seen from the scanner (master) and the RAM (slave).
interface pov_column_scanner_if #(
  parameter int COLS_LOG2 = 7,
  parameter int LED_W     = 8
);
  // rd_en is a single-cycle strobe with rd_addr; rd_data is valid the cycle after, no back-pressure.
  logic                 rd_en;
  logic [COLS_LOG2-1:0] rd_addr;
  logic [LED_W-1:0]     rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/pov_column_scanner.sv
// POV column scanner: measures the hall period, slices it into column slots and plays RAM columns to the LEDs.
// Optional macro POV_REVERSE_SCAN_EN plays the frame last column first.
module pov_column_scanner #(
  parameter int COLS_LOG2 = 7,
  parameter int LED_W     = 8,
  parameter int CNT_W     = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hall_in,
  input  logic                   buf_valid,
  pov_column_scanner_if.master   ram,
  output logic [LED_W-1:0]       leds,
  output logic                   scanning,
  output logic                   frame_done,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_SCAN    = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [COLS_LOG2-1:0] LAST_COL = '1;
  localparam logic [COLS_LOG2-1:0] COL_ONE  = COLS_LOG2'(1);

`ifdef POV_REVERSE_SCAN_EN
  localparam logic [COLS_LOG2-1:0] START_ADDR = LAST_COL;
`else
  localparam logic [COLS_LOG2-1:0] START_ADDR = '0;
`endif

  state_t r_state;
  state_t w_next_state;

  logic                 r_hall_s1;
  logic                 r_hall_s2;
  logic                 r_hall_d;
  logic [CNT_W-1:0]     r_rev_cnt;
  logic [CNT_W-1:0]     r_period;
  logic [CNT_W-1:0]     r_col_timer;
  logic [COLS_LOG2-1:0] r_col_idx;
  logic [COLS_LOG2-1:0] r_rd_addr;
  logic                 r_rd_en;
  logic                 r_data_pend;
  logic [LED_W-1:0]     r_leds;
  logic                 r_frame_done;

  logic             w_hall_pulse;
  logic             w_stall;
  logic [CNT_W-1:0] w_col_shift;
  logic [CNT_W-1:0] w_col_period;
  logic             w_slot_end;
  logic             w_last_col;
  logic             w_start;
  logic             w_advance;
  logic             w_end_frame;
  logic             w_blank;

  assign w_hall_pulse = r_hall_s2 & ~r_hall_d;
  // A saturated revolution counter means the rotor has stopped; a coincident pulse still wins.
  assign w_stall      = (r_rev_cnt == CNT_MAX) && !w_hall_pulse;
  assign w_col_shift  = r_period >> COLS_LOG2;
  assign w_col_period = (w_col_shift == '0) ? CNT_ONE : w_col_shift;
  assign w_slot_end   = (r_col_timer == (w_col_period - CNT_ONE));
  assign w_last_col   = (r_col_idx == LAST_COL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_end_frame  = 1'b0;
    w_blank      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hall_pulse) w_next_state = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_stall) begin
          w_next_state = S_IDLE;
        end else if (w_hall_pulse && buf_valid) begin
          w_next_state = S_SCAN;
          w_start      = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_stall) begin
          w_next_state = S_IDLE;
          w_blank      = 1'b1;
        end else if (!buf_valid) begin
          w_next_state = S_MEASURE;
          w_blank      = 1'b1;
        end else if (w_hall_pulse) begin
          // A pulse landing on the very last cycle closes a complete frame; earlier ones truncate it.
          w_start     = 1'b1;
          w_end_frame = w_slot_end && w_last_col;
        end else if (w_slot_end) begin
          if (w_last_col) begin
            w_next_state = S_WAIT;
            w_end_frame  = 1'b1;
            w_blank      = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (w_stall) begin
          w_next_state = S_IDLE;
        end else if (!buf_valid) begin
          w_next_state = S_MEASURE;
        end else if (w_hall_pulse) begin
          w_next_state = S_SCAN;
          w_start      = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_blank      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hall_s1 <= 1'b0;
      r_hall_s2 <= 1'b0;
      r_hall_d  <= 1'b0;
      r_rev_cnt <= '0;
      r_period  <= '0;
    end else begin
      r_hall_s1 <= hall_in;
      r_hall_s2 <= r_hall_s1;
      r_hall_d  <= r_hall_s2;
      if (w_hall_pulse) begin
        r_rev_cnt <= '0;
        r_period  <= (r_rev_cnt == CNT_MAX) ? CNT_MAX : (r_rev_cnt + CNT_ONE);
      end else begin
        if (r_rev_cnt != CNT_MAX) r_rev_cnt <= r_rev_cnt + CNT_ONE;
        if (w_stall) r_period <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_idx    <= '0;
      r_col_timer  <= '0;
      r_rd_addr    <= '0;
      r_rd_en      <= 1'b0;
      r_data_pend  <= 1'b0;
      r_leds       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= w_start | w_advance;
      r_data_pend  <= r_rd_en;
      r_frame_done <= w_end_frame;
      if (w_start) begin
        r_col_idx   <= '0;
        r_col_timer <= '0;
        r_rd_addr   <= START_ADDR;
      end else if (w_advance) begin
        r_col_idx   <= r_col_idx + COL_ONE;
        r_col_timer <= '0;
`ifdef POV_REVERSE_SCAN_EN
        r_rd_addr   <= r_rd_addr - COL_ONE;
`else
        r_rd_addr   <= r_rd_addr + COL_ONE;
`endif
      end else if (r_state == S_SCAN) begin
        r_col_timer <= r_col_timer + CNT_ONE;
      end
      if (w_blank) begin
        r_leds <= '0;
      end else if (r_data_pend && (r_state == S_SCAN)) begin
        r_leds <= ram.rd_data;
      end
    end
  end

  // Fresh RAM data is forwarded in its arrival cycle and then held from r_leds for the rest of the slot.
  assign leds        = (r_state != S_SCAN) ? '0 : (r_data_pend ? ram.rd_data : r_leds);
  assign ram.rd_en   = r_rd_en;
  assign ram.rd_addr = r_rd_addr;
  assign scanning    = (r_state == S_SCAN);
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pov_column_scanner.sv
// Directed bench for pov_column_scanner: reset, steady rotation, speed-up, buffer drop, stall and resume.
module tb_pov_column_scanner;
  localparam int COLS_LOG2 = 3;
  localparam int LED_W     = 8;
  localparam int CNT_W     = 10;
`ifdef POV_REVERSE_SCAN_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0, ST_MEASURE = 2'd1, ST_SCAN = 2'd2, ST_WAIT = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             hall_in;
  logic             buf_valid;
  logic [LED_W-1:0] leds;
  logic             scanning;
  logic             frame_done;
  logic [1:0]       dbg_state;

  pov_column_scanner_if #(.COLS_LOG2(COLS_LOG2), .LED_W(LED_W)) ram_if();

  pov_column_scanner #(.COLS_LOG2(COLS_LOG2), .LED_W(LED_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hall_in    (hall_in),
    .buf_valid  (buf_valid),
    .ram        (ram_if),
    .leds       (leds),
    .scanning   (scanning),
    .frame_done (frame_done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // column RAM model: registered read, data one cycle after rd_en
  logic [LED_W-1:0] mem [0:7];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ram_if.rd_data <= '0;
    else if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int rd_cnt   = 0;
  int cyc      = 0;
  int rd_snap  = 0;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (ram_if.rd_en) rd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic hall_rise();
    hall_in = 1'b1;
    fork
      begin
        repeat (4) @(negedge clk);
        hall_in = 1'b0;
      end
    join_none
  endtask

  function automatic int exp_addr(input int c);
    return REV ? (7 - c) : c;
  endfunction

  function automatic logic [31:0] exp_led(input int c);
    logic [7:0] one;
    one = 8'h01;
    return 32'(one << exp_addr(c));
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h01 << i;
    reset_n   = 1'b0;
    hall_in   = 1'b0;
    buf_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hall_in = ~hall_in;
      buf_valid = 1'b1;
    end
    check_eq("rst_leds", 32'(leds), 0);
    check_eq("rst_rd_en", 32'(ram_if.rd_en), 0);
    check_eq("rst_scanning", 32'(scanning), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    hall_in = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // steady rotation, 800-cycle period
    goto(0);    hall_rise();
    goto(10);   check_eq("first_pulse_measure", 32'(dbg_state), 32'(ST_MEASURE));
    goto(799);
    check_eq("pre_scan_scanning", 32'(scanning), 0);
    check_eq("pre_scan_leds", 32'(leds), 0);
    check_eq("pre_scan_fd", 32'(fd_cnt), 0);
    goto(800);  hall_rise();
    for (int c = 0; c < 8; c++) begin
      goto(803 + 100 * c);
      check_eq($sformatf("a_rd_en_c%0d", c), 32'(ram_if.rd_en), 1);
      check_eq($sformatf("a_rd_addr_c%0d", c), 32'(ram_if.rd_addr), 32'(exp_addr(c)));
      if (c == 0) begin
        check_eq("a_scanning", 32'(scanning), 1);
        check_eq("a_leds_before_data", 32'(leds), 0);
      end
      goto(804 + 100 * c);
      check_eq($sformatf("a_leds_first_c%0d", c), 32'(leds), exp_led(c));
      goto(853 + 100 * c);
      check_eq($sformatf("a_rd_en_mid_c%0d", c), 32'(ram_if.rd_en), 0);
      check_eq($sformatf("a_leds_mid_c%0d", c), 32'(leds), exp_led(c));
      if (c < 7) begin
        goto(902 + 100 * c);
        check_eq($sformatf("a_leds_last_c%0d", c), 32'(leds), exp_led(c));
      end
    end
    goto(1600); hall_rise();
    goto(1610); check_eq("fd_after_rev1", 32'(fd_cnt), 1);
    check_eq("rev2_scanning", 32'(scanning), 1);
    goto(2400); hall_rise();
    goto(2410); check_eq("fd_after_rev2", 32'(fd_cnt), 2);

    // speed-up: next pulse after 400 cycles
    goto(2800); hall_rise();
    goto(2803);
    check_eq("su_rd_en_c0", 32'(ram_if.rd_en), 1);
    check_eq("su_rd_addr_c0", 32'(ram_if.rd_addr), 32'(exp_addr(0)));
    goto(2804); check_eq("su_leds_c0", 32'(leds), exp_led(0));
    goto(2828); check_eq("su_rd_en_mid", 32'(ram_if.rd_en), 0);
    goto(2853);
    check_eq("su_rd_en_c1", 32'(ram_if.rd_en), 1);
    check_eq("su_rd_addr_c1", 32'(ram_if.rd_addr), 32'(exp_addr(1)));
    goto(2854); check_eq("su_leds_c1", 32'(leds), exp_led(1));
    goto(2860); check_eq("su_no_fd", 32'(fd_cnt), 2);

    // buffer drop during column 3
    goto(2958); check_eq("bd_leds_c3", 32'(leds), exp_led(3));
    goto(2960); buf_valid = 1'b0;
    goto(2961);
    check_eq("bd_leds_blank", 32'(leds), 0);
    check_eq("bd_state", 32'(dbg_state), 32'(ST_MEASURE));
    check_eq("bd_scanning", 32'(scanning), 0);
    rd_snap = rd_cnt;
    goto(3200); hall_rise();
    goto(3203);
    check_eq("bd_hold_state", 32'(dbg_state), 32'(ST_MEASURE));
    check_eq("bd_no_reads", 32'(rd_cnt), 32'(rd_snap));
    goto(3300); buf_valid = 1'b1;
    goto(3600); hall_rise();
    goto(3603);
    check_eq("bd_resume_rd_en", 32'(ram_if.rd_en), 1);
    check_eq("bd_resume_addr", 32'(ram_if.rd_addr), 32'(exp_addr(0)));
    goto(3604); check_eq("bd_resume_leds", 32'(leds), exp_led(0));

    // frame completes into WAIT, then the rotor stalls
    goto(4010);
    check_eq("wait_fd", 32'(fd_cnt), 3);
    check_eq("wait_leds", 32'(leds), 0);
    goto(4600); check_eq("stall_pre_state", 32'(dbg_state), 32'(ST_WAIT));
    goto(4640);
    check_eq("stall_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("stall_leds", 32'(leds), 0);
    goto(4700); hall_rise();
    goto(4705);
    check_eq("resume1_state", 32'(dbg_state), 32'(ST_MEASURE));
    check_eq("resume1_scanning", 32'(scanning), 0);
    goto(5100); hall_rise();
    goto(5103);
    check_eq("resume2_rd_en", 32'(ram_if.rd_en), 1);
    check_eq("resume2_scanning", 32'(scanning), 1);
    goto(5104); check_eq("resume2_leds", 32'(leds), exp_led(0));

    // asynchronous reset in the middle of a slot
    goto(5120);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_leds", 32'(leds), 0);
    check_eq("mid_rst_scanning", 32'(scanning), 0);
    check_eq("mid_rst_rd_en", 32'(ram_if.rd_en), 0);
    check_eq("mid_rst_rd_addr", 32'(ram_if.rd_addr), 0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
